// File: rtl/decode_pipe.sv
// Decode-to-execute pipeline stage: register file with writeback bypass,
// load-use interlock and the registered EX-stage bundle.
module decode_pipe #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int CTRL_W   = 16,
    parameter int LOAD_BIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_d,
    input  logic [XLEN-1:0]   pc_d,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [XLEN-1:0]   imm_d,
    input  logic              we_w,
    input  logic [4:0]        rd_w,
    input  logic [XLEN-1:0]   wd_w,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] ctrl_e,
    output logic [XLEN-1:0]   r1_e,
    output logic [XLEN-1:0]   r2_e,
    output logic [XLEN-1:0]   imm_e,
    output logic [XLEN-1:0]   pc_e,
    output logic [4:0]        rd_e,
    output logic [4:0]        rs1_e,
    output logic [4:0]        rs2_e,
    output logic              valid_e,
    output logic              stall_d,
    output logic [15:0]       hz_cnt
);
    localparam int IDX_W = $clog2(NREG);

    logic [XLEN-1:0] rf_r [NREG];
    logic [15:0]     hz_cnt_r;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0] r1_s, r2_s;
    logic            hz_s, wr_ok_s;
    logic            unused_instr_s;

    // Indices beyond the implemented file (NREG=16) behave like absent registers.
    function automatic logic idx_in_range(input logic [4:0] idx);
        return ({1'b0, idx} < 6'(NREG));
    endfunction

    assign rs1_s          = instr_d[19:15];
    assign rs2_s          = instr_d[24:20];
    assign rd_s           = instr_d[11:7];
    assign unused_instr_s = ^{instr_d[31:25], instr_d[14:12], instr_d[6:0]};
    assign wr_ok_s        = we_w && (rd_w != 5'd0) && idx_in_range(rd_w);
    assign hz_cnt         = hz_cnt_r;

    // Source operand reads with same-cycle writeback forwarding.
    always_comb begin
        r1_s = '0;
        r2_s = '0;
        if (rs1_s == 5'd0 || !idx_in_range(rs1_s)) begin
            r1_s = '0;
        end else if (we_w && rd_w == rs1_s) begin
            r1_s = wd_w;
        end else begin
            r1_s = rf_r[rs1_s[IDX_W-1:0]];
        end
        if (rs2_s == 5'd0 || !idx_in_range(rs2_s)) begin
            r2_s = '0;
        end else if (we_w && rd_w == rs2_s) begin
            r2_s = wd_w;
        end else begin
            r2_s = rf_r[rs2_s[IDX_W-1:0]];
        end
    end

    // Load-use hazard detection and the hold request to fetch/decode.
    always_comb begin
        hz_s    = valid_e && ctrl_e[LOAD_BIT] && (rd_e != 5'd0) && valid_d &&
                  ((rd_e == rs1_s) || (rd_e == rs2_s));
        stall_d = stall_i || (hz_s && !flush_i);
    end

    // Register file storage; x0 and out-of-range writes never land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            rf_r[rd_w[IDX_W-1:0]] <= wd_w;
        end
    end

    // EX bundle update: flush beats external stall, which beats the interlock bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_e   <= '0;
            r1_e     <= '0;
            r2_e     <= '0;
            imm_e    <= '0;
            pc_e     <= '0;
            rd_e     <= 5'd0;
            rs1_e    <= 5'd0;
            rs2_e    <= 5'd0;
            valid_e  <= 1'b0;
            hz_cnt_r <= 16'd0;
        end else if (flush_i) begin
            valid_e <= 1'b0;
            ctrl_e  <= '0;
            rd_e    <= 5'd0;
        end else if (stall_i) begin
            valid_e <= valid_e;
        end else if (hz_s) begin
            valid_e  <= 1'b0;
            ctrl_e   <= '0;
            rd_e     <= 5'd0;
            hz_cnt_r <= (hz_cnt_r == 16'hFFFF) ? 16'hFFFF : hz_cnt_r + 16'd1;
        end else begin
            ctrl_e  <= valid_d ? ctrl_d : '0;
            r1_e    <= r1_s;
            r2_e    <= r2_s;
            imm_e   <= imm_d;
            pc_e    <= pc_d;
            rd_e    <= rd_s;
            rs1_e   <= rs1_s;
            rs2_e   <= rs2_s;
            valid_e <= valid_d;
        end
    end
endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: a 32-entry and a 16-entry instance share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_decode_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_d, pc_d, imm_d, wd_w;
    logic        valid_d, we_w, stall_i, flush_i;
    logic [15:0] ctrl_d;
    logic [4:0]  rd_w;

    logic [1:0][15:0] ctrl_e, hz_cnt;
    logic [1:0][31:0] r1_e, r2_e, imm_e, pc_e;
    logic [1:0][4:0]  rd_e, rs1_e, rs2_e;
    logic [1:0]       valid_e, stall_d;

    int n_pass  = 0;
    int n_total = 0;
    bit run     = 1'b0;

    // Model state, index 0 = NREG 32, index 1 = NREG 16
    logic [31:0] m_rf [2][32];
    logic [15:0] m_ctrl [2];
    logic [15:0] m_cnt [2];
    logic [31:0] m_r1 [2], m_r2 [2], m_imm [2], m_pc [2];
    logic [4:0]  m_rd [2], m_rs1 [2], m_rs2 [2];
    logic        m_valid [2];

    decode_pipe #(.XLEN(32), .NREG(32), .CTRL_W(16), .LOAD_BIT(3)) dut_a (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .ctrl_d(ctrl_d), .imm_d(imm_d), .we_w(we_w), .rd_w(rd_w), .wd_w(wd_w),
        .stall_i(stall_i), .flush_i(flush_i), .ctrl_e(ctrl_e[0]), .r1_e(r1_e[0]),
        .r2_e(r2_e[0]), .imm_e(imm_e[0]), .pc_e(pc_e[0]), .rd_e(rd_e[0]),
        .rs1_e(rs1_e[0]), .rs2_e(rs2_e[0]), .valid_e(valid_e[0]),
        .stall_d(stall_d[0]), .hz_cnt(hz_cnt[0]));

    decode_pipe #(.XLEN(32), .NREG(16), .CTRL_W(16), .LOAD_BIT(3)) dut_b (
        .clk(clk), .rst(rst), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
        .ctrl_d(ctrl_d), .imm_d(imm_d), .we_w(we_w), .rd_w(rd_w), .wd_w(wd_w),
        .stall_i(stall_i), .flush_i(flush_i), .ctrl_e(ctrl_e[1]), .r1_e(r1_e[1]),
        .r2_e(r2_e[1]), .imm_e(imm_e[1]), .pc_e(pc_e[1]), .rd_e(rd_e[1]),
        .rs1_e(rs1_e[1]), .rs2_e(rs2_e[1]), .valid_e(valid_e[1]),
        .stall_d(stall_d[1]), .hz_cnt(hz_cnt[1]));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int nreg(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= nreg(k)) return 32'd0;
        if (we_w && rd_w == idx) return wd_w;
        return m_rf[k][idx];
    endfunction

    function automatic bit m_hz(input int k);
        return m_valid[k] && m_ctrl[k][3] && (m_rd[k] != 5'd0) && valid_d &&
               ((m_rd[k] == instr_d[19:15]) || (m_rd[k] == instr_d[24:20]));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m_rf[k][i] = 32'd0;
            m_ctrl[k] = 16'd0; m_cnt[k] = 16'd0; m_r1[k] = 32'd0; m_r2[k] = 32'd0;
            m_imm[k] = 32'd0; m_pc[k] = 32'd0; m_rd[k] = 5'd0; m_rs1[k] = 5'd0;
            m_rs2[k] = 5'd0; m_valid[k] = 1'b0;
        end
    endtask

    task automatic m_step();
        logic [31:0] a, b;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_reset();
            end else begin
                a = m_read(k, instr_d[19:15]);
                b = m_read(k, instr_d[24:20]);
                if (flush_i) begin
                    m_valid[k] = 1'b0; m_ctrl[k] = 16'd0; m_rd[k] = 5'd0;
                end else if (stall_i) begin
                    m_valid[k] = m_valid[k];
                end else if (m_hz(k)) begin
                    m_valid[k] = 1'b0; m_ctrl[k] = 16'd0; m_rd[k] = 5'd0;
                    if (m_cnt[k] != 16'hFFFF) m_cnt[k] = m_cnt[k] + 16'd1;
                end else begin
                    m_ctrl[k] = valid_d ? ctrl_d : 16'd0;
                    m_r1[k] = a; m_r2[k] = b; m_imm[k] = imm_d; m_pc[k] = pc_d;
                    m_rd[k] = instr_d[11:7]; m_rs1[k] = instr_d[19:15];
                    m_rs2[k] = instr_d[24:20]; m_valid[k] = valid_d;
                end
                if (we_w && rd_w != 5'd0 && int'(rd_w) < nreg(k)) m_rf[k][rd_w] = wd_w;
            end
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("stall_d[%0d]", k), stall_d[k], stall_i | (m_hz(k) & ~flush_i));
                chk($sformatf("valid_e[%0d]", k), valid_e[k], m_valid[k]);
                chk($sformatf("ctrl_e[%0d]", k), ctrl_e[k], m_ctrl[k]);
                chk($sformatf("rd_e[%0d]", k), rd_e[k], m_rd[k]);
                chk($sformatf("hz_cnt[%0d]", k), hz_cnt[k], m_cnt[k]);
                if (m_valid[k]) begin
                    chk($sformatf("r1_e[%0d]", k), r1_e[k], m_r1[k]);
                    chk($sformatf("r2_e[%0d]", k), r2_e[k], m_r2[k]);
                    chk($sformatf("imm_e[%0d]", k), imm_e[k], m_imm[k]);
                    chk($sformatf("pc_e[%0d]", k), pc_e[k], m_pc[k]);
                    chk($sformatf("rs1_e[%0d]", k), rs1_e[k], m_rs1[k]);
                    chk($sformatf("rs2_e[%0d]", k), rs2_e[k], m_rs2[k]);
                end
            end
        end
    end

    task automatic idle();
        instr_d = 32'd0; pc_d = 32'd0; imm_d = 32'd0; valid_d = 1'b0; ctrl_d = 16'd0;
        we_w = 1'b0; rd_w = 5'd0; wd_w = 32'd0; stall_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic setd(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [15:0] ctrl, input logic [31:0] pc);
        instr_d = {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
        valid_d = 1'b1; ctrl_d = ctrl; pc_d = pc; imm_d = pc ^ 32'h5A5A0000;
    endtask

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got no summary, expected one");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid_e", valid_e[0], 64'd0);
        chk("reset hz_cnt", hz_cnt[0], 64'd0);
        chk("reset stall_d", stall_d[0], 64'd0);
        run = 1'b1;
        rst = 1'b1;

        // writeback bypass and register-file boundaries
        we_w = 1'b1; rd_w = 5'd5; wd_w = 32'hDEADBEEF;
        setd(5'd1, 5'd5, 5'd0, 16'h0011, 32'h100);
        cyc();
        chk("bypass r1_e", r1_e[0], 64'hDEADBEEF);
        chk("bypass r1_e n16", r1_e[1], 64'hDEADBEEF);
        chk("first capture valid_e", valid_e[0], 64'd1);
        chk("first capture pc_e", pc_e[0], 64'h100);
        rd_w = 5'd20; wd_w = 32'h12345678;
        setd(5'd2, 5'd20, 5'd5, 16'h0012, 32'h104);
        cyc();
        chk("rd20 bypass n32", r1_e[0], 64'h12345678);
        chk("rs1=20 reads 0 n16", r1_e[1], 64'd0);
        chk("r2 from file", r2_e[0], 64'hDEADBEEF);
        rd_w = 5'd0; wd_w = 32'hFFFFFFFF;
        setd(5'd3, 5'd20, 5'd0, 16'h0013, 32'h108);
        cyc();
        chk("rd20 stored n32", r1_e[0], 64'h12345678);
        chk("rd20 dropped n16", r1_e[1], 64'd0);
        chk("x0 write ignored", r2_e[0], 64'd0);
        we_w = 1'b0;

        // load-use interlock
        setd(5'd7, 5'd5, 5'd0, 16'h0008, 32'h200);
        cyc();
        setd(5'd8, 5'd1, 5'd7, 16'h0001, 32'h204);
        #1 chk("load-use stall_d", stall_d[0], 64'd1);
        cyc();
        chk("load-use bubble", valid_e[0], 64'd0);
        chk("load-use hz_cnt", hz_cnt[0], 64'd1);
        cyc();
        chk("load-use add valid", valid_e[0], 64'd1);
        chk("load-use add rd", rd_e[0], 64'd8);

        // flush wins over hazard
        setd(5'd7, 5'd5, 5'd0, 16'h0008, 32'h300);
        cyc();
        setd(5'd9, 5'd7, 5'd2, 16'h0001, 32'h304);
        flush_i = 1'b1;
        #1 chk("flush stall_d", stall_d[0], 64'd0);
        cyc();
        chk("flush bubble", valid_e[0], 64'd0);
        chk("flush ctrl_e", ctrl_e[0], 64'd0);
        chk("flush hz_cnt", hz_cnt[0], 64'd1);
        flush_i = 1'b0;

        // external stall hold, then capture on release
        setd(5'd9, 5'd5, 5'd1, 16'h0002, 32'h400);
        cyc();
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setd(5'(10 + i), 5'd3, 5'd4, 16'(4 + i), 32'h500 + 32'(4 * i));
            #1 chk("stall stall_d", stall_d[0], 64'd1);
            cyc();
            chk("stall hold pc_e", pc_e[0], 64'h400);
            chk("stall hold rd_e", rd_e[0], 64'd9);
        end
        stall_i = 1'b0;
        setd(5'd12, 5'd5, 5'd5, 16'h0020, 32'h600);
        cyc();
        chk("release pc_e", pc_e[0], 64'h600);
        chk("release rd_e", rd_e[0], 64'd12);
        valid_d = 1'b0; ctrl_d = 16'hFFFF;
        cyc();
        chk("invalid ctrl forced 0", ctrl_e[0], 64'd0);

        // saturation from a preloaded counter
        setd(5'd7, 5'd5, 5'd0, 16'h0008, 32'h700);
        cyc();
        force dut_a.hz_cnt_r = 16'hFFFE;
        m_cnt[0] = 16'hFFFE;
        #1 release dut_a.hz_cnt_r;
        setd(5'd8, 5'd7, 5'd0, 16'h0001, 32'h704);
        cyc();
        chk("hz_cnt reaches FFFF", hz_cnt[0], 64'hFFFF);
        cyc();
        setd(5'd7, 5'd5, 5'd0, 16'h0008, 32'h708);
        cyc();
        setd(5'd8, 5'd0, 5'd7, 16'h0001, 32'h70C);
        cyc();
        chk("hz_cnt saturates", hz_cnt[0], 64'hFFFF);

        // async reset in the middle of a stalled hazard
        setd(5'd7, 5'd5, 5'd0, 16'h0008, 32'h800);
        cyc();
        setd(5'd8, 5'd7, 5'd7, 16'h0001, 32'h804);
        stall_i = 1'b1;
        #1 rst = 1'b0;
        m_reset();
        #1;
        chk("async rst valid_e", valid_e[0], 64'd0);
        chk("async rst ctrl_e", ctrl_e[0], 64'd0);
        chk("async rst rd_e", rd_e[0], 64'd0);
        chk("async rst pc_e", pc_e[0], 64'd0);
        chk("async rst hz_cnt", hz_cnt[0], 64'd0);
        chk("async rst hz_cnt n16", hz_cnt[1], 64'd0);
        rst = 1'b1;
        stall_i = 1'b0;
        setd(5'd8, 5'd5, 5'd20, 16'h0001, 32'h808);
        #1 chk("post-reset stall_d", stall_d[0], 64'd0);
        cyc();
        chk("post-reset valid_e", valid_e[0], 64'd1);
        chk("post-reset rf cleared", r1_e[0], 64'd0);
        chk("post-reset pc_e", pc_e[0], 64'h808);
        cyc();

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
